// File: rtl/seq_frac_divider.sv
// rtl/seq_frac_divider.sv - fixed-latency restoring divider producing a saturated QW-bit fraction
module seq_frac_divider #(
  parameter int NW = 16,
  parameter int QW = 8
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [NW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [QW-1:0] quotient_o,
  output logic          saturated_o,
  output logic          div_zero_o
);

  localparam int CW = $clog2(QW);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t        state_q;
  logic [NW:0]   rem_q;
  logic [NW:0]   rem_d;
  logic [NW-1:0] dvsr_q;
  logic [CW-1:0] cnt_q;
  logic [QW-1:0] qbits_q;
  logic [QW-1:0] qbits_d;
  logic          div_zero_n_q;
  logic          sat_n_q;
  logic          done_q;
  logic [QW-1:0] quotient_q;
  logic          saturated_q;
  logic          div_zero_q;

  logic [NW+1:0] rem_shift;
  logic          rem_ge;

  // One restoring step; the wide shift keeps the compare exact even when the
  // remainder starts at or above the divisor (saturated case, result discarded).
  always_comb begin
    rem_shift = {rem_q, 1'b0};
    rem_ge    = (rem_shift >= {2'b00, dvsr_q});
    rem_d     = (NW+1)'(rem_ge ? (rem_shift - {2'b00, dvsr_q}) : rem_shift);
    qbits_d   = QW'({qbits_q, rem_ge});
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      dvsr_q       <= '0;
      cnt_q        <= '0;
      qbits_q      <= '0;
      div_zero_n_q <= 1'b0;
      sat_n_q      <= 1'b0;
      done_q       <= 1'b0;
      quotient_q   <= '0;
      saturated_q  <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_q        <= {1'b0, dividend_i};
            dvsr_q       <= divisor_i;
            cnt_q        <= '0;
            qbits_q      <= '0;
            div_zero_n_q <= (divisor_i == '0);
            sat_n_q      <= (dividend_i >= divisor_i);
            state_q      <= CALC;
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          qbits_q <= qbits_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
            if (div_zero_n_q) begin
              quotient_q  <= '1;
              saturated_q <= 1'b1;
              div_zero_q  <= 1'b1;
            end else if (sat_n_q) begin
              quotient_q  <= '1;
              saturated_q <= 1'b1;
              div_zero_q  <= 1'b0;
            end else begin
              quotient_q  <= qbits_d;
              saturated_q <= 1'b0;
              div_zero_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == CALC);
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign saturated_o = saturated_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_frac_divider.sv
// tb/tb_seq_frac_divider.sv - directed self-checking bench for seq_frac_divider
module tb_seq_frac_divider;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic        saturated;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_frac_divider #(.NW(16), .QW(8)) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .busy_o      (busy),
    .done_o      (done),
    .quotient_o  (quotient),
    .saturated_o (saturated),
    .div_zero_o  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] q, input logic s, input logic z);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    wait_done(lat);
    check({tag, ".lat"}, lat, 8);
    check({tag, ".q"}, quotient, q);
    check({tag, ".sat"}, saturated, s);
    check({tag, ".dz"}, div_zero, z);
    check({tag, ".busy_end"}, busy, 0);
    @(negedge clk);
    check({tag, ".pulse"}, done, 0);
    check({tag, ".hold"}, quotient, q);
  endtask

  initial begin
    int lat;
    int lat2;
    int ndone;
    nrst     = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.q", quotient, 0);
    check("rst.sat", saturated, 0);
    check("rst.dz", div_zero, 0);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst.busy", busy, 0);
    check("post_rst.done", done, 0);

    run_div("nominal", 16'd22000, 16'd22727, 8'd247, 1'b0, 1'b0);
    run_div("sat_eq",  16'd22727, 16'd22727, 8'd255, 1'b1, 1'b0);
    run_div("zero_num", 16'd0,    16'd22727, 8'd0,   1'b0, 1'b0);
    run_div("half",    16'd11363, 16'd22727, 8'd127, 1'b0, 1'b0);
    run_div("div0",    16'd500,   16'd0,     8'd255, 1'b1, 1'b1);
    run_div("tiny",    16'd1,     16'd65535, 8'd0,   1'b0, 1'b0);
    run_div("near1",   16'd65534, 16'd65535, 8'd255, 1'b0, 1'b0);

    // start and operand changes mid-flight are ignored
    @(negedge clk);
    dividend = 16'd22000;
    divisor  = 16'd22727;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) begin
        ndone++;
        check("ignore.q", quotient, 247);
      end
      @(negedge clk);
    end
    check("ignore.ndone", ndone, 1);

    // asynchronous reset mid-calculation aborts the operation
    dividend = 16'd11363;
    divisor  = 16'd22727;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy_before", busy, 1);
    nrst = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.q", quotient, 0);
    @(negedge clk);
    nrst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort.ndone", ndone, 0);
    check("abort.idle", busy, 0);

    // start held across done: the second operation starts with no gap
    dividend = 16'd22000;
    divisor  = 16'd22727;
    start    = 1'b1;
    @(negedge clk);
    wait_done(lat);
    check("b2b.lat1", lat, 8);
    check("b2b.q1", quotient, 247);
    dividend = 16'd11363;
    @(negedge clk);
    check("b2b.accept", busy, 1);
    start = 1'b0;
    wait_done(lat2);
    check("b2b.gap", lat + lat2 + 1, 17);
    check("b2b.q2", quotient, 127);
    @(negedge clk);
    check("b2b.idle", busy, 0);
    check("b2b.pulse", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_frac_divider.md
SEQ_FRAC_DIVIDER -- requirements
Module: seq_frac_divider

Interface
REQ-001 Parameter NW, default 16, meaning dividend/divisor width in bits (NW >= 2).
REQ-002 Parameter QW, default 8, meaning quotient width in bits (2 <= QW <= NW).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new division; sampled only in IDLE.
REQ-006 dividend  input  NW  unsigned numerator, sampled on the accepting edge.
REQ-007 divisor  input  NW  unsigned denominator, sampled on the accepting edge.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new result.
REQ-010 quotient  output  QW  registered result; holds until the next done.
REQ-011 saturated  output  1  result was clipped to all ones; updated with done.
REQ-012 div_zero  output  1  divisor was zero; updated with done.

Function
REQ-013 Result SHALL be quotient = min(floor(dividend * 2^QW / divisor), 2^QW - 1).
REQ-014 The block SHALL have states IDLE and CALC.
REQ-015 In IDLE, start=1 on a rising edge SHALL latch dividend and divisor, clear the bit counter, and enter CALC.
REQ-016 In IDLE with start=0, all registers SHALL hold.
REQ-017 busy SHALL equal (state == CALC).
REQ-018 The accepting edge SHALL precompute two flags: div_zero_n = (divisor == 0) and sat_n = (dividend >= divisor).
REQ-019 CALC SHALL run restoring division, one quotient bit per cycle, MSB first.
  - Remainder: NW+1 bits, initialised to the latched dividend.
  - Each cycle: shift the remainder left by 1.
  - If the shifted remainder is >= divisor, subtract divisor and shift in 1; otherwise shift in 0.
REQ-020 CALC SHALL last exactly QW cycles regardless of operand values, giving fixed latency.
REQ-021 On the final CALC edge, the block SHALL:
  - write quotient, saturated and div_zero;
  - set done=1 for exactly one cycle;
  - return to IDLE.
REQ-022 Total latency SHALL be QW rising edges from the accepting edge to the edge that asserts done.
REQ-023 If div_zero_n=1, quotient SHALL be 2^QW-1, with div_zero=1 and saturated=1.
REQ-024 If sat_n=1 and divisor != 0, quotient SHALL be 2^QW-1, with saturated=1 and div_zero=0.
REQ-025 Otherwise, quotient SHALL be the computed bits, with saturated=0 and div_zero=0.
REQ-026 start asserted while busy=1 SHALL be ignored; it is neither queued nor able to alter the operation in flight.
REQ-027 Operand changes while busy=1 SHALL NOT affect the result.
REQ-028 Back-to-back: start=1 in the cycle where done=1 SHALL be accepted on the next edge, with no idle gap required.
REQ-029 dividend=0 with divisor != 0 SHALL yield quotient=0 and saturated=0.

Reset
REQ-030 nrst=0 SHALL immediately, without waiting for a clock edge, force state=IDLE and clear the internal remainder and counter.
REQ-031 nrst=0 SHALL immediately force busy=0, done=0, quotient=0, saturated=0 and div_zero=0.
REQ-032 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow the release of reset.
REQ-033 After nrst rises, the first start SHALL be accepted on the next rising edge.

Verification (NW=16, QW=8)
REQ-034 Reset: hold nrst=0 for 2 cycles, then release at negedge -> all outputs 0; after 1 cycle, busy=0 and done=0.
REQ-035 Nominal: dividend=22000, divisor=22727, 1-cycle start -> busy for 8 cycles, then done pulse; quotient=247, saturated=0.
REQ-036 Saturation: dividend=22727, divisor=22727 -> quotient=255, saturated=1, div_zero=0.
REQ-037 Then dividend=0 -> quotient=0, saturated=0. Then dividend=11363 -> quotient=127.
REQ-038 Zero divisor: dividend=500, divisor=0 -> done after 8 cycles; quotient=255, div_zero=1, saturated=1.
REQ-039 Protocol:
  - start pulsed and operands changed at CALC cycle 3 -> original result delivered, exactly one done pulse.
  - nrst pulsed at CALC cycle 4 -> outputs cleared, no done pulse.
  - start held high across done -> second result 8 cycles later.
